// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Contents:
//   S_IDLE / S_SHIFT / S_DONE  FSM state encodings
//   sub_ovf()                  signed-overflow rule for A-B from the sign bits
package serial_sub_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // A-B overflows when the operands have opposite signs and the result sign
  // differs from the minuend sign.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_adder.sv
// Single-bit full-adder cell reused by the serial subtractor.
// Ports:
//   a, b  operand bits
//   ci    carry in
//   s     sum bit
//   co    carry out
module serial_subtractor_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor behind a valid/ready handshake.
// One full-adder cell computes A + ~B + 1 LSB-first over WIDTH cycles.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the Ovf (signed overflow) port.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands A,B presented
//   in_ready   idle, operands accepted
//   A, B       minuend, subtrahend
//   out_valid  Diff/Bout(/Ovf) valid, held until out_ready
//   out_ready  consumer accepts result
//   Diff       (A-B) mod 2**WIDTH
//   Bout       borrow, 1 iff unsigned A < B
//   Ovf        signed overflow (SERIAL_SUB_OVF_EN only)
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_r;
  logic             carry_r;
  logic             bout_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             fa_sum_s;
  logic             fa_co_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
  logic             ovf_r;
`endif

  // b_sh_r already holds ~B and carry starts at 1, so the cell adds A + ~B + 1.
  serial_subtractor_full_adder u_fa (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .ci (carry_r),
    .s  (fa_sum_s),
    .co (fa_co_s)
  );

  // FSM, bit counter, operand/result shift registers and carry flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      diff_r      <= '0;
      carry_r     <= 1'b0;
      bout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r     <= 1'b0;
      b_msb_r     <= 1'b0;
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid && in_ready_r) begin
            a_sh_r     <= A;
            b_sh_r     <= ~B;
            carry_r    <= 1'b1;
            cnt_r      <= '0;
            diff_r     <= '0;
            bout_r     <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r    <= A[WIDTH-1];
            b_msb_r    <= B[WIDTH-1];
            ovf_r      <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          // Each sum bit enters at the MSB; after WIDTH shifts bit 0 lands at Diff[0].
          diff_r  <= {fa_sum_s, diff_r[WIDTH-1:1]};
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= fa_co_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_BIT) begin
            state_r     <= S_DONE;
            out_valid_r <= 1'b1;
            // No final carry out of A + ~B + 1 means a borrow occurred.
            bout_r      <= ~fa_co_s;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r       <= sub_ovf(a_msb_r, b_msb_r, fa_sum_s);
`endif
          end
        end
        S_DONE: begin
          if (out_valid_r && out_ready) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Diff      = diff_r;
  assign Bout      = bout_r;
`ifdef SERIAL_SUB_OVF_EN
  assign Ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             ovf_s;

  int checks = 0;
  int errors = 0;

  // expected {diff, bout, ovf}
  logic [WIDTH+1:0] exp_q[$];

  serial_subtractor #(.WIDTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Ovf       (ovf_s)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf_s = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per accepted result.
  always @(negedge clk) begin
    if (!rst) begin
      chk("no_overlap", 32'(in_ready & out_valid), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          logic [WIDTH+1:0] e;
          e = exp_q.pop_front();
          chk("diff", 32'(Diff), 32'(e[WIDTH+1:2]));
          chk("bout", 32'(Bout), 32'(e[1]));
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", 32'(ovf_s), 32'(e[0]));
`endif
        end
      end
    end
  end

  // Waits for in_ready, presents one operand pair for one cycle, then scrambles A/B.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] ed,
                       input logic eb, input logic eo, input bit push);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("in_ready_timeout", 32'd1, 32'd0);
    A = a; B = b; in_valid = 1'b1;
    if (push) exp_q.push_back({ed, eb, eo});
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 4'($urandom); B = 4'($urandom);
  endtask

  // Counts edges from acceptance until out_valid rises.
  task automatic wait_done(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(n), 32'(WIDTH));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] md;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = 4'd0; B = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(Diff), 32'd0);
    chk("rst_bout", 32'(Bout), 32'd0);

    // basic vectors with latency checks
    issue(4'd9, 4'd3, 4'd6, 1'b0, 1'b1, 1'b1);   wait_done("lat_9_3");
    issue(4'd3, 4'd9, 4'hA, 1'b1, 1'b1, 1'b1);   wait_done("lat_3_9");
    issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);   wait_done("lat_0_0");
    issue(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1); wait_done("lat_15_15");

    // result held while out_ready=0; in_valid pulses ignored
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(4'd5, 4'd1, 4'd4, 1'b0, 1'b0, 1'b1);
    wait_done("lat_5_1");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; A = 4'd14; B = 4'd2;
      @(posedge clk); #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_diff", 32'(Diff), 32'd4);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;

    // back-to-back
    issue(4'd12, 4'd4, 4'd8, 1'b0, 1'b0, 1'b1); wait_done("lat_12_4");
    issue(4'd4, 4'd12, 4'd8, 1'b1, 1'b1, 1'b1); wait_done("lat_4_12");

    // reset during the second SHIFT cycle
    issue(4'd6, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_diff", 32'(Diff), 32'd0);
    issue(4'd10, 4'd7, 4'd3, 1'b0, 1'b1, 1'b1); wait_done("lat_10_7");

    // signed overflow corner vectors
    issue(4'd7, 4'd8, 4'hF, 1'b1, 1'b1, 1'b1); wait_done("lat_7_8");
    issue(4'd2, 4'd1, 4'd1, 1'b0, 1'b0, 1'b1); wait_done("lat_2_1");

    // exhaustive sweep against a reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        md = 4'(a - b);
        issue(4'(a), 4'(b), md, (a < b) ? 1'b1 : 1'b0,
              ((a >= 8) != (b >= 8)) && ((md[3] == 1'b1) != (a >= 8)), 1'b1);
      end
    end

    repeat (10) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
